pwm_deadtime_gen: RTL and testbench

- Complementary PWM generator with dead-time insertion.
- Sits directly downstream of the 16-bit MMIO register bank and consumes its four direct outputs: carrier (reg0), modulation (reg1), dead time (reg2) and mode (reg3).
- Drives one high-side/low-side gate pair and a period-start strobe used for ADC and software sync.

---
 rtl/pwm_deadtime_gen_if.sv | 23 ++
 rtl/pwm_deadtime_gen.sv | 145 ++++++++++++++
 tb/tb_pwm_deadtime_gen.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_deadtime_gen_if.sv
// rtl/pwm_deadtime_gen_if.sv - register-bank to PWM generator signal bundle
interface pwm_deadtime_gen_if #(
    parameter int CNT_W = 16
);
    logic [CNT_W-1:0] carrier;
    logic [CNT_W-1:0] modulation;
    logic [CNT_W-1:0] dead_time;
    logic [15:0]      mode;
    logic             pwm_h;
    logic             pwm_l;
    logic             period_tick;
    logic [CNT_W-1:0] counter;

    modport master (
        output carrier, modulation, dead_time, mode,
        input  pwm_h, pwm_l, period_tick, counter
    );

    modport slave (
        input  carrier, modulation, dead_time, mode,
        output pwm_h, pwm_l, period_tick, counter
    );
endinterface

// File: rtl/pwm_deadtime_gen.sv
// rtl/pwm_deadtime_gen.sv - complementary PWM generator with dead-time insertion
module pwm_deadtime_gen #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    pwm_deadtime_gen_if.slave bus
);
    typedef enum logic [2:0] {IDLE, H_ON, DT_HL, L_ON, DT_LH} state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    logic en, center, inv, brake, mode_unused;
    assign en          = bus.mode[0];
    assign center      = bus.mode[1];
    assign inv         = bus.mode[2];
    assign brake       = bus.mode[3];
    assign mode_unused = ^bus.mode[15:4];

    logic [CNT_W-1:0] counter_q, counter_d;
    logic             down_q, down_d;
    logic [CNT_W-1:0] car_sh_q, mod_sh_q, dt_sh_q;
    logic             center_sh_q;
    logic             ref_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] dt_cnt_q, dt_cnt_d;
    logic             pwm_h_q, pwm_l_q, tick_q;
    logic             load_sh;
    logic [CNT_W-1:0] car_in;

    assign car_in = (bus.carrier < TWO) ? TWO : bus.carrier;

    // Counter; load_sh marks the edge where the counter returns to 0.
    always_comb begin
        counter_d = counter_q;
        down_d    = down_q;
        load_sh   = 1'b0;
        if (!en) begin
            counter_d = '0;
            down_d    = 1'b0;
            load_sh   = 1'b1;
        end else if (!center_sh_q) begin
            if (counter_q >= car_sh_q - ONE) begin
                counter_d = '0;
                load_sh   = 1'b1;
            end else begin
                counter_d = counter_q + ONE;
            end
        end else if (!down_q) begin
            if (counter_q >= car_sh_q) begin
                counter_d = counter_q - ONE;
                down_d    = 1'b1;
            end else begin
                counter_d = counter_q + ONE;
            end
        end else if (counter_q <= ONE) begin
            counter_d = '0;
            down_d    = 1'b0;
            load_sh   = 1'b1;
        end else begin
            counter_d = counter_q - ONE;
        end
    end

    // Dead-time FSM: a DT state falls back to the side it left if ref returns.
    always_comb begin
        state_d  = state_q;
        dt_cnt_d = dt_cnt_q;
        if (!en || brake) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = ref_q ? DT_LH : DT_HL;
                    dt_cnt_d = dt_sh_q;
                end
                H_ON: if (!ref_q) begin
                    if (dt_sh_q == '0) begin
                        state_d = L_ON;
                    end else begin
                        state_d  = DT_HL;
                        dt_cnt_d = dt_sh_q - ONE;
                    end
                end
                DT_HL: begin
                    if (ref_q)                 state_d  = H_ON;
                    else if (dt_cnt_q == '0)   state_d  = L_ON;
                    else                       dt_cnt_d = dt_cnt_q - ONE;
                end
                L_ON: if (ref_q) begin
                    if (dt_sh_q == '0) begin
                        state_d = H_ON;
                    end else begin
                        state_d  = DT_LH;
                        dt_cnt_d = dt_sh_q - ONE;
                    end
                end
                DT_LH: begin
                    if (!ref_q)                state_d  = L_ON;
                    else if (dt_cnt_q == '0)   state_d  = H_ON;
                    else                       dt_cnt_d = dt_cnt_q - ONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter_q   <= '0;
            down_q      <= 1'b0;
            car_sh_q    <= TWO;
            mod_sh_q    <= '0;
            dt_sh_q     <= '0;
            center_sh_q <= 1'b0;
            ref_q       <= 1'b0;
            state_q     <= IDLE;
            dt_cnt_q    <= '0;
            pwm_h_q     <= 1'b0;
            pwm_l_q     <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            counter_q <= counter_d;
            down_q    <= down_d;
            if (load_sh) begin
                car_sh_q    <= car_in;
                mod_sh_q    <= bus.modulation;
                dt_sh_q     <= bus.dead_time;
                center_sh_q <= center;
            end
            ref_q    <= (counter_q < mod_sh_q);
            state_q  <= state_d;
            dt_cnt_q <= dt_cnt_d;
            pwm_h_q  <= (state_d == H_ON) ^ inv;
            pwm_l_q  <= (state_d == L_ON) ^ inv;
            tick_q   <= en && (counter_d == '0);
        end
    end

    assign bus.pwm_h       = pwm_h_q;
    assign bus.pwm_l       = pwm_l_q;
    assign bus.period_tick = tick_q;
    assign bus.counter     = counter_q;
endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// tb/tb_pwm_deadtime_gen.sv - self-checking bench for pwm_deadtime_gen
module tb_pwm_deadtime_gen;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pwm_deadtime_gen_if #(.CNT_W(CNT_W)) bus ();
    pwm_deadtime_gen #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model: position within the period plus a ref-history gate rule.
    int m_pos, m_car, m_mod, m_dt, m_run, m_from_start, m_favor, m_cnt;
    bit m_ctr, m_ref, m_prev_ref, m_active, m_h, m_l, m_tick;

    function automatic int cnt_of(int pos);
        if (m_ctr) return (pos <= m_car) ? pos : 2 * m_car - pos;
        return pos;
    endfunction

    task automatic model_update();
        bit en, brk, inv, on_h, on_l, ref_next, load;
        int want, need, period;
        if (rst) begin
            m_pos = 0; m_car = 2; m_mod = 0; m_dt = 0; m_ctr = 0;
            m_ref = 0; m_prev_ref = 0; m_active = 0; m_run = 0; m_from_start = 0;
            m_favor = 0; m_h = 0; m_l = 0; m_tick = 0; m_cnt = 0;
            return;
        end
        en = bus.mode[0]; brk = bus.mode[3]; inv = bus.mode[2];
        on_h = 0; on_l = 0; load = 0;
        if (!en || brk) begin
            m_active = 0;
        end else begin
            if (!m_active) begin
                m_active = 1; m_run = 1; m_from_start = 1;
                m_favor = m_ref ? 2 : 1;
            end else if (m_ref == m_prev_ref) begin
                m_run++;
            end else begin
                m_run = 1; m_from_start = 0;
            end
            m_prev_ref = m_ref;
            want = m_ref ? 1 : 2;
            need = m_dt + 1 + m_from_start;
            if (m_favor == want || m_run >= need) begin
                m_favor = want;
                on_h = (want == 1);
                on_l = (want == 2);
            end
        end
        m_h = on_h ^ inv;
        m_l = on_l ^ inv;
        ref_next = (cnt_of(m_pos) < m_mod);
        period = m_ctr ? 2 * m_car : m_car;
        if (!en) begin
            m_pos = 0; load = 1;
        end else begin
            m_pos++;
            if (m_pos >= period) begin m_pos = 0; load = 1; end
        end
        if (load) begin
            m_car = (int'(bus.carrier) < 2) ? 2 : int'(bus.carrier);
            m_mod = int'(bus.modulation);
            m_dt  = int'(bus.dead_time);
            m_ctr = bus.mode[1];
        end
        m_tick = en && (m_pos == 0);
        m_ref  = ref_next;
        m_cnt  = cnt_of(m_pos);
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
        vectors++;
        if (bus.pwm_h !== m_h || bus.pwm_l !== m_l || bus.period_tick !== m_tick ||
            int'(bus.counter) != m_cnt) begin
            miscompares++;
            $display("FAIL model cyc=%0d h=%b exp %b l=%b exp %b tick=%b exp %b cnt=%0d exp %0d",
                     cyc, bus.pwm_h, m_h, bus.pwm_l, m_l, bus.period_tick, m_tick,
                     bus.counter, m_cnt);
        end
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_eq(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_in(int car, int modv, int dt, int mode);
        bus.carrier    = 16'(car);
        bus.modulation = 16'(modv);
        bus.dead_time  = 16'(dt);
        bus.mode       = 16'(mode);
    endtask

    typedef struct {
        int carrier; int modulation; int dead_time; int mode;
        int period; int h_per; int l_per; int gap_per; int tick_per;
    } vec_t;

    vec_t tv[7];

    initial begin
        int ticks, hc, lc, gc, prev_cnt, mod_r, dt_r, car_r, mode_r, seg_len;
        bit found;

        tv[0] = '{10, 4, 0, 'h0001, 10, 4, 6, 0, 1};
        tv[1] = '{10, 4, 2, 'h0001, 10, 2, 4, 4, 1};
        tv[2] = '{8, 3, 1, 'h0003, 16, 4, 10, 2, 1};
        tv[3] = '{10, 1, 3, 'h0001, 10, 0, 9, 1, 1};
        tv[4] = '{10, 20, 0, 'h0001, 10, 10, 0, 0, 1};
        tv[5] = '{0, 1, 0, 'h0001, 2, 1, 1, 0, 1};
        tv[6] = '{10, 4, 0, 'h0004, 10, 10, 10, 0, 0};

        // Reset with random inputs: outputs must stay at zero.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in($urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 5),
                   int'($urandom_range(0, 65535)));
            step();
            check_eq($sformatf("reset%0d pwm_h", i), int'(bus.pwm_h), 0);
            check_eq($sformatf("reset%0d pwm_l", i), int'(bus.pwm_l), 0);
            check_eq($sformatf("reset%0d counter", i), int'(bus.counter), 0);
            check_eq($sformatf("reset%0d tick", i), int'(bus.period_tick), 0);
        end
        rst = 1'b0;

        // Steady-state counts per configuration over four whole periods.
        for (int i = 0; i < 7; i++) begin
            set_in(tv[i].carrier, tv[i].modulation, tv[i].dead_time, tv[i].mode & 'hFFFE);
            run(2);
            set_in(tv[i].carrier, tv[i].modulation, tv[i].dead_time, tv[i].mode);
            run(40);
            ticks = 0; hc = 0; lc = 0; gc = 0;
            for (int c = 0; c < 4 * tv[i].period; c++) begin
                step();
                ticks += int'(bus.period_tick);
                hc    += int'(bus.pwm_h);
                lc    += int'(bus.pwm_l);
                gc    += int'(!bus.pwm_h && !bus.pwm_l);
            end
            check_eq($sformatf("vec%0d ticks", i), ticks, 4 * tv[i].tick_per);
            check_eq($sformatf("vec%0d h_cycles", i), hc, 4 * tv[i].h_per);
            check_eq($sformatf("vec%0d l_cycles", i), lc, 4 * tv[i].l_per);
            check_eq($sformatf("vec%0d gap_cycles", i), gc, 4 * tv[i].gap_per);
        end

        // Mid-period modulation write only takes effect in the next period.
        set_in(10, 4, 0, 'h0000);
        run(2);
        set_in(10, 4, 0, 'h0001);
        run(25);
        found = 0;
        for (int c = 0; c < 30 && !found; c++) begin
            step();
            found = bus.period_tick;
        end
        check_eq("shadow tick_found", int'(found), 1);
        hc = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.counter == 16'd5) bus.modulation = 16'd7;
            step();
            hc += int'(bus.pwm_h);
        end
        check_eq("shadow current_period_h", hc, 4);
        hc = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            hc += int'(bus.pwm_h);
        end
        check_eq("shadow next_period_h", hc, 7);

        // Brake forces both gates inactive on the next edge; counter keeps running.
        run(3);
        prev_cnt = int'(bus.counter);
        bus.mode = 16'h0009;
        step();
        check_eq("brake pwm_h", int'(bus.pwm_h), 0);
        check_eq("brake pwm_l", int'(bus.pwm_l), 0);
        check_eq("brake counter", int'(bus.counter), (prev_cnt + 1) % 10);
        run(5);
        bus.mode = 16'h0001;
        run(30);

        // Randomized segments against the model; dead time fixed within a segment.
        for (int s = 0; s < 24; s++) begin
            car_r  = $urandom_range(0, 12);
            mod_r  = $urandom_range(0, 26);
            dt_r   = $urandom_range(0, 4);
            mode_r = int'($urandom_range(0, 4095)) << 4 | int'($urandom_range(0, 1)) << 1 |
                     int'($urandom_range(0, 1)) << 2;
            set_in(car_r, mod_r, dt_r, mode_r);
            run(2);
            mode_r = mode_r | 1;
            bus.mode = 16'(mode_r);
            seg_len = $urandom_range(60, 150);
            for (int c = 0; c < seg_len; c++) begin
                if ($urandom_range(0, 15) == 0) bus.modulation = 16'($urandom_range(0, 26));
                if ($urandom_range(0, 39) == 0) bus.carrier = 16'($urandom_range(0, 12));
                if ($urandom_range(0, 31) == 0) bus.mode[3] = ~bus.mode[3];
                if ($urandom_range(0, 31) == 0) bus.mode[2] = ~bus.mode[2];
                if ($urandom_range(0, 49) == 0) bus.mode[1] = ~bus.mode[1];
                bus.mode[0] = ($urandom_range(0, 59) != 0);
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
